exhaustive_pattern_sweeper: RTL and testbench

//  Synthesizable exhaustive-stimulus engine for combinational/sequential DUT characterisation.
//  - Drives every input pattern 0 .. 2**N_IN-1 in ascending order.
//  - Waits SETTLE cycles per pattern, then samples the DUT response.
//  - Folds each response into a MISR signature.
//  - Optionally streams {pattern,response} records over a valid/ready port.
//  - Sits between the trojan-detection harness and the DUT; generalises the fixed 6-input sweep to any width/settle/output count.

---
 rtl/exhaustive_pattern_sweeper_pkg.sv | 18 +
 rtl/exhaustive_pattern_sweeper_if.sv | 29 ++
 rtl/exhaustive_pattern_sweeper_sig_misr.sv | 36 +++
 rtl/exhaustive_pattern_sweeper.sv | 195 +++++++++++++++++++
 tb/tb_exhaustive_pattern_sweeper.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exhaustive_pattern_sweeper_pkg.sv
// Shared types and sizing helpers for the exhaustive pattern sweeper.
package exhaustive_pattern_sweeper_pkg;

    // Sweep controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Width of the settle counter; never narrower than one bit
    function automatic int unsigned settle_cnt_w(input int unsigned settle);
        return (settle < 2) ? 32'd1 : 32'($clog2(settle + 1));
    endfunction

endpackage

// File: rtl/exhaustive_pattern_sweeper_if.sv
// Control, DUT-facing and record-stream signals of the sweeper.
interface exhaustive_pattern_sweeper_if #(
    parameter int unsigned N_IN  = 6,
    parameter int unsigned N_OUT = 1,
    parameter int unsigned SIG_W = 16
);
    logic                    start;
    logic                    stream_en;
    logic [N_IN-1:0]         pat_o;
    logic [N_OUT-1:0]        dut_resp_i;
    logic                    rec_valid;
    logic                    rec_ready;
    logic [N_IN+N_OUT-1:0]   rec_data;
    logic                    busy;
    logic                    done;
    logic [SIG_W-1:0]        signature;

    // Sweeper side
    modport master (
        input  start, stream_en, dut_resp_i, rec_ready,
        output pat_o, rec_valid, rec_data, busy, done, signature
    );

    // Harness / sink side
    modport slave (
        output start, stream_en, dut_resp_i, rec_ready,
        input  pat_o, rec_valid, rec_data, busy, done, signature
    );
endinterface

// File: rtl/exhaustive_pattern_sweeper_sig_misr.sv
// Multiple-input signature register folding one response per enabled cycle.
module exhaustive_pattern_sweeper_sig_misr #(
    parameter int unsigned          SIG_W    = 16,
    parameter logic [SIG_W-1:0]     SIG_POLY = 16'h1021,
    parameter int unsigned          N_OUT    = 1
) (
    input  logic                CK,
    input  logic                reset,
    input  logic                clr,
    input  logic                en,
    input  logic [N_OUT-1:0]    din,
    output logic [SIG_W-1:0]    sig
);

    logic [SIG_W-1:0] fb_c;

    // Polynomial feedback selected by the bit shifted out
    always_comb begin
        fb_c = '0;
        if (sig[SIG_W-1]) begin
            fb_c = SIG_POLY;
        end
    end

    // Signature register: clear on start, fold response on sample
    always_ff @(posedge CK) begin
        if (!reset) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= (sig << 1) ^ fb_c ^ SIG_W'(din);
        end
    end

endmodule

// File: rtl/exhaustive_pattern_sweeper.sv
// Exhaustive stimulus engine: walks every input pattern, samples the DUT,
// folds responses into a MISR and optionally streams {pattern,response}.
module exhaustive_pattern_sweeper
    import exhaustive_pattern_sweeper_pkg::*;
#(
    parameter int unsigned          N_IN     = 6,
    parameter int unsigned          N_OUT    = 1,
    parameter int unsigned          SETTLE   = 1,
    parameter int unsigned          SIG_W    = 16,
    parameter logic [SIG_W-1:0]     SIG_POLY = 16'h1021
) (
    input  logic                        CK,
    input  logic                        reset,
    exhaustive_pattern_sweeper_if.master bus
);

    // One extra counter bit keeps the terminal compare free of overflow
    localparam int unsigned PAT_W = N_IN + 1;
    localparam int unsigned CNT_W = settle_cnt_w(SETTLE);
    localparam int unsigned REC_W = N_IN + N_OUT;

    localparam logic [PAT_W-1:0] PAT_LAST    = PAT_W'((64'd1 << N_IN) - 64'd1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    state_t             state_q;
    state_t             state_d;

    logic [PAT_W-1:0]   pat_cnt_q;
    logic [CNT_W-1:0]   settle_cnt_q;
    logic               stream_q;
    logic               busy_q;
    logic               done_q;
    logic               rec_valid_q;
    logic [REC_W-1:0]   rec_data_q;
    logic [SIG_W-1:0]   sig_q;

    logic               settle_done_c;
    logic               last_pat_c;
    logic               handshake_c;
    logic               launch_c;
    logic               settle_step_c;
    logic               sample_c;
    logic               emit_load_c;
    logic               ack_c;
    logic               advance_c;
    logic               finish_c;

    // Status terms shared by next-state and strobe logic
    always_comb begin
        settle_done_c = (settle_cnt_q == SETTLE_LAST);
        last_pat_c    = (pat_cnt_q == PAT_LAST);
        handshake_c   = rec_valid_q && bus.rec_ready;
    end

    // State register
    always_ff @(posedge CK) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done_c) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (stream_q) begin
                    state_d = ST_EMIT;
                end else if (last_pat_c) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_EMIT: begin
                if (handshake_c) begin
                    state_d = last_pat_c ? ST_DONE : ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        launch_c      = 1'b0;
        settle_step_c = 1'b0;
        sample_c      = 1'b0;
        emit_load_c   = 1'b0;
        ack_c         = 1'b0;
        advance_c     = 1'b0;
        finish_c      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                launch_c = bus.start;
            end
            ST_SETTLE: begin
                settle_step_c = 1'b1;
            end
            ST_SAMPLE: begin
                sample_c = 1'b1;
                if (stream_q) begin
                    emit_load_c = 1'b1;
                end else if (last_pat_c) begin
                    finish_c = 1'b1;
                end else begin
                    advance_c = 1'b1;
                end
            end
            ST_EMIT: begin
                if (handshake_c) begin
                    ack_c = 1'b1;
                    if (last_pat_c) begin
                        finish_c = 1'b1;
                    end else begin
                        advance_c = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Pattern/settle counters, status flags and the record register
    always_ff @(posedge CK) begin
        if (!reset) begin
            pat_cnt_q    <= '0;
            settle_cnt_q <= '0;
            stream_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rec_valid_q  <= 1'b0;
            rec_data_q   <= '0;
        end else begin
            if (launch_c) begin
                pat_cnt_q    <= '0;
                settle_cnt_q <= '0;
                stream_q     <= bus.stream_en;
                busy_q       <= 1'b1;
                done_q       <= 1'b0;
            end
            if (settle_step_c) begin
                settle_cnt_q <= settle_done_c ? '0 : settle_cnt_q + CNT_W'(1);
            end
            if (emit_load_c) begin
                rec_valid_q <= 1'b1;
                rec_data_q  <= {pat_cnt_q[N_IN-1:0], bus.dut_resp_i};
            end
            if (ack_c) begin
                rec_valid_q <= 1'b0;
            end
            if (advance_c) begin
                pat_cnt_q <= pat_cnt_q + PAT_W'(1);
            end
            if (finish_c) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    // Response signature
    exhaustive_pattern_sweeper_sig_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY),
        .N_OUT    (N_OUT)
    ) u_misr (
        .CK    (CK),
        .reset (reset),
        .clr   (launch_c),
        .en    (sample_c),
        .din   (bus.dut_resp_i),
        .sig   (sig_q)
    );

    assign bus.pat_o     = pat_cnt_q[N_IN-1:0];
    assign bus.rec_valid = rec_valid_q;
    assign bus.rec_data  = rec_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = sig_q;

endmodule

// File: tb/tb_exhaustive_pattern_sweeper.sv
// Directed bench: small 2-input sweeper for protocol cases, 6-input one for the long sweep.
module tb_exhaustive_pattern_sweeper;

    logic CK = 1'b0;
    logic reset_a;
    logic reset_b;
    logic resp_sel;
    int   tests_run    = 0;
    int   tests_failed = 0;

    exhaustive_pattern_sweeper_if #(.N_IN(2), .N_OUT(1), .SIG_W(8))  if_a ();
    exhaustive_pattern_sweeper_if #(.N_IN(6), .N_OUT(1), .SIG_W(16)) if_b ();

    always #5 CK = ~CK;

    // DUT models: constant 1 or pat[0] for the small sweeper, AND-reduce for the wide one
    always_comb if_a.dut_resp_i = resp_sel ? if_a.pat_o[0] : 1'b1;
    always_comb if_b.dut_resp_i = &if_b.pat_o;

    exhaustive_pattern_sweeper #(
        .N_IN(2), .N_OUT(1), .SETTLE(1), .SIG_W(8), .SIG_POLY(8'h1D)
    ) dut_a (
        .CK    (CK),
        .reset (reset_a),
        .bus   (if_a)
    );

    exhaustive_pattern_sweeper #(
        .N_IN(6), .N_OUT(1), .SETTLE(3), .SIG_W(16), .SIG_POLY(16'h1021)
    ) dut_b (
        .CK    (CK),
        .reset (reset_b),
        .bus   (if_b)
    );

    task automatic run_sweep_a(output int cyc);
        @(negedge CK) if_a.start = 1'b1;
        @(negedge CK) if_a.start = 1'b0;
        cyc = 0;
        while (!if_a.done && cyc < 200) begin
            @(negedge CK);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (2) @(negedge CK);
        tests_run++;
        if (if_a.pat_o !== 2'd0) begin tests_failed++; $display("FAIL reset_pat got %0h want 0", if_a.pat_o); end
        tests_run++;
        if ({if_a.rec_valid, if_a.busy, if_a.done} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_flags got %b want 000", {if_a.rec_valid, if_a.busy, if_a.done});
        end
        tests_run++;
        if (if_a.rec_data !== 3'd0) begin tests_failed++; $display("FAIL reset_rec_data got %0h want 0", if_a.rec_data); end
        tests_run++;
        if (if_a.signature !== 8'h00) begin tests_failed++; $display("FAIL reset_sig got %0h want 0", if_a.signature); end
        tests_run++;
        if ({if_b.busy, if_b.done, if_b.signature} !== 18'd0) begin
            tests_failed++; $display("FAIL reset_b got busy=%b done=%b sig=%0h want 0", if_b.busy, if_b.done, if_b.signature);
        end
        reset_a = 1'b1;
        reset_b = 1'b1;
        @(negedge CK);
    endtask

    task automatic test_sweep_no_stream();
        int cyc;
        int err;
        logic [1:0] exp_pat;
        resp_sel = 1'b0;
        if_a.stream_en = 1'b0;
        if_a.rec_ready = 1'b0;
        @(negedge CK) if_a.start = 1'b1;
        @(negedge CK) if_a.start = 1'b0;
        tests_run++;
        if ({if_a.busy, if_a.done, if_a.pat_o} !== 4'b1000) begin
            tests_failed++; $display("FAIL ns_launch got busy=%b done=%b pat=%0d want 1 0 0", if_a.busy, if_a.done, if_a.pat_o);
        end
        cyc = 0;
        err = 0;
        while (!if_a.done && cyc < 100) begin
            @(negedge CK);
            cyc++;
            exp_pat = 2'((cyc >= 7) ? 3 : cyc / 2);
            if (if_a.pat_o !== exp_pat || if_a.rec_valid !== 1'b0) err++;
        end
        tests_run++;
        if (err != 0) begin tests_failed++; $display("FAIL ns_pat_seq got %0d bad cycles want 0", err); end
        tests_run++;
        if (cyc != 8) begin tests_failed++; $display("FAIL ns_cycles got %0d want 8", cyc); end
        tests_run++;
        if (if_a.signature !== 8'h0F) begin tests_failed++; $display("FAIL ns_sig got %0h want 0f", if_a.signature); end
        tests_run++;
        if ({if_a.busy, if_a.pat_o} !== 3'b011) begin
            tests_failed++; $display("FAIL ns_final got busy=%b pat=%0d want 0 3", if_a.busy, if_a.pat_o);
        end
    endtask

    task automatic test_stream();
        int cyc;
        int nrec;
        logic [2:0] recs [4];
        logic [2:0] exp_rec [4];
        exp_rec = '{3'b000, 3'b011, 3'b100, 3'b111};
        resp_sel = 1'b1;
        if_a.stream_en = 1'b1;
        if_a.rec_ready = 1'b1;
        @(negedge CK) if_a.start = 1'b1;
        @(negedge CK) if_a.start = 1'b0;
        cyc = 0;
        nrec = 0;
        while (!if_a.done && cyc < 100) begin
            @(negedge CK);
            cyc++;
            if (if_a.rec_valid) begin
                if (nrec < 4) recs[nrec] = if_a.rec_data;
                nrec++;
            end
        end
        tests_run++;
        if (nrec != 4) begin tests_failed++; $display("FAIL st_count got %0d want 4", nrec); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i < nrec && recs[i] !== exp_rec[i]) begin
                tests_failed++; $display("FAIL st_rec%0d got %b want %b", i, recs[i], exp_rec[i]);
            end
        end
        tests_run++;
        if (cyc != 12) begin tests_failed++; $display("FAIL st_cycles got %0d want 12", cyc); end
        tests_run++;
        if (if_a.signature !== 8'h05) begin tests_failed++; $display("FAIL st_sig got %0h want 05", if_a.signature); end
    endtask

    task automatic test_stall();
        int cyc;
        int nrec;
        int stall;
        int hold_err;
        logic [2:0] recs [4];
        logic [2:0] exp_rec [4];
        exp_rec = '{3'b000, 3'b011, 3'b100, 3'b111};
        resp_sel = 1'b1;
        if_a.stream_en = 1'b1;
        if_a.rec_ready = 1'b1;
        @(negedge CK) if_a.start = 1'b1;
        @(negedge CK) if_a.start = 1'b0;
        cyc = 0;
        nrec = 0;
        stall = 0;
        hold_err = 0;
        while (!if_a.done && cyc < 200) begin
            @(negedge CK);
            cyc++;
            if (if_a.rec_valid) begin
                if (nrec == 1 && stall < 5) begin
                    if_a.rec_ready = 1'b0;
                    stall++;
                    if (if_a.rec_data !== 3'b011 || if_a.pat_o !== 2'd1) hold_err++;
                end else begin
                    if_a.rec_ready = 1'b1;
                    if (nrec < 4) recs[nrec] = if_a.rec_data;
                    nrec++;
                end
            end else begin
                if_a.rec_ready = 1'b1;
            end
        end
        tests_run++;
        if (stall != 5 || hold_err != 0) begin
            tests_failed++; $display("FAIL sl_hold got stall=%0d errs=%0d want 5 0", stall, hold_err);
        end
        tests_run++;
        if (nrec != 4) begin tests_failed++; $display("FAIL sl_count got %0d want 4", nrec); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (i < nrec && recs[i] !== exp_rec[i]) begin
                tests_failed++; $display("FAIL sl_rec%0d got %b want %b", i, recs[i], exp_rec[i]);
            end
        end
        tests_run++;
        if (cyc != 17) begin tests_failed++; $display("FAIL sl_cycles got %0d want 17", cyc); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        resp_sel = 1'b0;
        if_a.stream_en = 1'b0;
        if_a.rec_ready = 1'b0;
        @(negedge CK) if_a.start = 1'b1;
        @(negedge CK) if_a.start = 1'b0;
        cyc = 0;
        while (if_a.pat_o !== 2'd2 && cyc < 50) begin
            @(negedge CK);
            cyc++;
        end
        tests_run++;
        if (if_a.pat_o !== 2'd2) begin tests_failed++; $display("FAIL rm_reach got pat=%0d want 2", if_a.pat_o); end
        reset_a = 1'b0;
        @(negedge CK);
        reset_a = 1'b1;
        tests_run++;
        if ({if_a.pat_o, if_a.busy, if_a.done, if_a.rec_valid} !== 5'd0 ||
            if_a.rec_data !== 3'd0 || if_a.signature !== 8'h00) begin
            tests_failed++;
            $display("FAIL rm_clear got pat=%0d busy=%b done=%b vld=%b data=%0h sig=%0h want all 0",
                     if_a.pat_o, if_a.busy, if_a.done, if_a.rec_valid, if_a.rec_data, if_a.signature);
        end
        repeat (3) @(negedge CK);
        tests_run++;
        if ({if_a.busy, if_a.pat_o} !== 3'b000) begin
            tests_failed++; $display("FAIL rm_no_resume got busy=%b pat=%0d want 0 0", if_a.busy, if_a.pat_o);
        end
        run_sweep_a(cyc);
        tests_run++;
        if (cyc != 8 || if_a.signature !== 8'h0F) begin
            tests_failed++; $display("FAIL rm_rerun got cycles=%0d sig=%0h want 8 0f", cyc, if_a.signature);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        resp_sel = 1'b0;
        if_a.stream_en = 1'b0;
        if_a.rec_ready = 1'b0;
        @(negedge CK) if_a.start = 1'b1;
        @(negedge CK) if_a.start = 1'b0;
        cyc = 0;
        repeat (3) begin @(negedge CK); cyc++; end
        if_a.start = 1'b1;
        @(negedge CK);
        cyc++;
        if_a.start = 1'b0;
        tests_run++;
        if (if_a.pat_o !== 2'd2) begin tests_failed++; $display("FAIL sb_ignored got pat=%0d want 2", if_a.pat_o); end
        while (!if_a.done && cyc < 100) begin
            @(negedge CK);
            cyc++;
        end
        tests_run++;
        if (cyc != 8 || if_a.signature !== 8'h0F) begin
            tests_failed++; $display("FAIL sb_first got cycles=%0d sig=%0h want 8 0f", cyc, if_a.signature);
        end
        repeat (2) @(negedge CK);
        tests_run++;
        if (if_a.done !== 1'b1) begin tests_failed++; $display("FAIL sb_done_held got %b want 1", if_a.done); end
        @(negedge CK) if_a.start = 1'b1;
        @(negedge CK) if_a.start = 1'b0;
        tests_run++;
        if ({if_a.done, if_a.busy, if_a.pat_o} !== 4'b0100 || if_a.signature !== 8'h00) begin
            tests_failed++;
            $display("FAIL sb_restart got done=%b busy=%b pat=%0d sig=%0h want 0 1 0 0",
                     if_a.done, if_a.busy, if_a.pat_o, if_a.signature);
        end
        cyc = 0;
        while (!if_a.done && cyc < 100) begin
            @(negedge CK);
            cyc++;
        end
        tests_run++;
        if (cyc != 8 || if_a.signature !== 8'h0F) begin
            tests_failed++; $display("FAIL sb_second got cycles=%0d sig=%0h want 8 0f", cyc, if_a.signature);
        end
    endtask

    task automatic test_wide_sweep();
        int cyc;
        int nrec;
        int ones;
        int seq_err;
        if_b.stream_en = 1'b1;
        if_b.rec_ready = 1'b1;
        @(negedge CK) if_b.start = 1'b1;
        @(negedge CK) if_b.start = 1'b0;
        cyc = 0;
        nrec = 0;
        ones = 0;
        seq_err = 0;
        while (!if_b.done && cyc < 1000) begin
            @(negedge CK);
            cyc++;
            if (if_b.rec_valid) begin
                if (if_b.rec_data[6:1] !== 6'(nrec)) seq_err++;
                if (if_b.rec_data[0] !== (nrec == 63)) seq_err++;
                if (if_b.rec_data[0] === 1'b1) ones++;
                nrec++;
            end
        end
        tests_run++;
        if (nrec != 64) begin tests_failed++; $display("FAIL wd_count got %0d want 64", nrec); end
        tests_run++;
        if (ones != 1 || seq_err != 0) begin
            tests_failed++; $display("FAIL wd_records got ones=%0d errs=%0d want 1 0", ones, seq_err);
        end
        tests_run++;
        if (cyc != 320) begin tests_failed++; $display("FAIL wd_cycles got %0d want 320", cyc); end
        tests_run++;
        if (if_b.signature !== 16'h0001 || if_b.pat_o !== 6'h3F) begin
            tests_failed++; $display("FAIL wd_final got sig=%0h pat=%0h want 0001 3f", if_b.signature, if_b.pat_o);
        end
    endtask

    initial begin
        reset_a        = 1'b0;
        reset_b        = 1'b0;
        resp_sel       = 1'b0;
        if_a.start     = 1'b0;
        if_a.stream_en = 1'b0;
        if_a.rec_ready = 1'b0;
        if_b.start     = 1'b0;
        if_b.stream_en = 1'b0;
        if_b.rec_ready = 1'b0;

        test_reset();
        test_sweep_no_stream();
        test_stream();
        test_stall();
        test_reset_mid();
        test_start_while_busy();
        test_wide_sweep();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
